ahb_arbiter: RTL and testbench

- Round-robin bus arbiter that shares one AHB bus among NUM_MST masters.
- Takes per-master request and lock inputs plus the muxed master-side htrans/hburst and the bus hready.
- Drives one-hot hgrant, the address-phase owner index hmaster (select for the master-side mux), and hmastlock.
- Fixed-length bursts and locked sequences are never split; when nobody requests, the bus parks on DEFAULT_MST.

---
 rtl/ahb_arbiter_if.sv | 25 ++
 rtl/ahb_arbiter.sv | 151 +++++++++++++++
 tb/tb_ahb_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_if.sv
// Arbitration signals between the AHB masters/bus fabric and the arbiter.
// "master" is the requesting side; "slave" is the arbiter's view.
interface ahb_arbiter_if #(
  parameter int NUM_MST = 4,
  parameter int MST_W   = $clog2(NUM_MST)
) ();
  logic [NUM_MST-1:0] hbusreq;
  logic [NUM_MST-1:0] hlock;
  logic [1:0]         htrans;
  logic [2:0]         hburst;
  logic               hready;
  logic [NUM_MST-1:0] hgrant;
  logic [MST_W-1:0]   hmaster;
  logic               hmastlock;

  modport master (
    output hbusreq, hlock, htrans, hburst, hready,
    input  hgrant, hmaster, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready,
    output hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: keeps fixed-length bursts and locked sequences whole,
// hands the address phase over one ready cycle after the grant, parks on DEFAULT_MST.
module ahb_arbiter #(
  parameter int NUM_MST     = 4,
  parameter int MST_W       = $clog2(NUM_MST),
  parameter int DEFAULT_MST = 0
) (
  input  logic         hclk,
  input  logic         hreset_n,
  ahb_arbiter_if.slave bus
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_PARK,
    ST_BURST,
    ST_LOCKED
  } state_e;

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [NUM_MST-1:0] hgrant_q, hgrant_d;
  logic [MST_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [MST_W-1:0]   hmaster_q, hmaster_d;
  logic               hmastlock_q, hmastlock_d;

  logic [NUM_MST-1:0] lock_req;
  logic               incr;
  logic               last_beat;
  logic               settled;
  logic               hold_lock;
  logic               rearb;
  logic [MST_W:0]     pick_res;
  logic               pick_found;
  logic [MST_W-1:0]   pick_idx;

  function automatic logic [4:0] burst_len_f(input logic [2:0] hb);
    logic [4:0] len;
    case (hb)
      3'b010, 3'b011: len = 5'd4;
      3'b100, 3'b101: len = 5'd8;
      3'b110, 3'b111: len = 5'd16;
      default:        len = 5'd1;   // SINGLE, and INCR which never counts
    endcase
    return len;
  endfunction

  // Returns {found, index}: first requester after base, base itself considered last.
  function automatic logic [MST_W:0] rr_pick(input logic [MST_W-1:0]   base,
                                             input logic [NUM_MST-1:0] req);
    logic [MST_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = MST_W'(DEFAULT_MST);
    found = 1'b0;
    for (int i = 1; i <= NUM_MST; i++) begin
      idx = int'(base) + i;
      if (idx >= NUM_MST) idx = idx - NUM_MST;
      if (!found && req[idx[MST_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[MST_W-1:0];
      end
    end
    return {found, pick};
  endfunction

  assign lock_req   = bus.hbusreq & bus.hlock;
  assign incr       = (bus.hburst == 3'b001);
  assign pick_res   = rr_pick(hmaster_q, bus.hbusreq);
  assign pick_found = pick_res[MST_W];
  assign pick_idx   = pick_res[MST_W-1:0];

  // While a new grant is still waiting for ownership, htrans belongs to the old owner.
  assign settled = (gnt_idx_q == hmaster_q);

  always_comb begin
    last_beat = 1'b0;
    case (bus.htrans)
      TR_IDLE:   last_beat = 1'b1;
      TR_BUSY:   last_beat = incr;
      TR_NONSEQ: last_beat = incr || (burst_len_f(bus.hburst) == 5'd1);
      TR_SEQ:    last_beat = incr || (cnt_q == 5'd1);
      default:   last_beat = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hgrant_d    = hgrant_q;
    gnt_idx_d   = gnt_idx_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    hold_lock   = 1'b0;
    rearb       = 1'b0;

    case (state_q)
      ST_LOCKED: hold_lock = lock_req[hmaster_q];
      default:   hold_lock = 1'b0;
    endcase

    if (bus.hready) begin
      hmaster_d   = gnt_idx_q;
      hmastlock_d = lock_req[gnt_idx_q];

      if (bus.htrans == TR_NONSEQ)
        cnt_d = burst_len_f(bus.hburst) - 5'd1;
      else if (bus.htrans == TR_SEQ && cnt_q != 5'd0)
        cnt_d = cnt_q - 5'd1;

      rearb = settled && last_beat && !hold_lock;
      if (rearb) begin
        gnt_idx_d = pick_idx;
        hgrant_d  = NUM_MST'(1) << pick_idx;
        if (!pick_found)
          state_d = ST_PARK;
        else if (lock_req[pick_idx])
          state_d = ST_LOCKED;
        else
          state_d = ST_BURST;
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= ST_PARK;
      cnt_q       <= 5'd0;
      hgrant_q    <= NUM_MST'(1) << DEFAULT_MST;
      gnt_idx_q   <= MST_W'(DEFAULT_MST);
      hmaster_q   <= MST_W'(DEFAULT_MST);
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hgrant_q    <= hgrant_d;
      gnt_idx_q   <= gnt_idx_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign bus.hgrant    = hgrant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter with four masters parked on master 0.
module tb_ahb_arbiter;
  localparam int NUM_MST = 4;
  localparam int MST_W   = 2;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic hclk = 1'b0;
  logic hreset_n;
  int   errors = 0;
  int   checks = 0;

  ahb_arbiter_if #(.NUM_MST(NUM_MST), .MST_W(MST_W)) bus ();

  ahb_arbiter #(.NUM_MST(NUM_MST), .MST_W(MST_W), .DEFAULT_MST(0)) dut (
    .hclk    (hclk),
    .hreset_n(hreset_n),
    .bus     (bus)
  );

  always #5 hclk = ~hclk;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic go_park();
    bus.hbusreq = '0;
    bus.hlock   = '0;
    bus.htrans  = IDLE;
    bus.hburst  = 3'b000;
    bus.hready  = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    hreset_n    = 1'b0;
    bus.hbusreq = '0;
    bus.hlock   = '0;
    bus.htrans  = IDLE;
    bus.hburst  = 3'b000;
    bus.hready  = 1'b1;
    repeat (2) step();
    hreset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({bus.hgrant, bus.hmaster, bus.hmastlock} !== {4'b0001, 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got grant=%b mst=%0d lock=%b want grant=0001 mst=0 lock=0",
                 i, bus.hgrant, bus.hmaster, bus.hmastlock);
      end
    end
  endtask

  task automatic test_park_grant();
    bus.hbusreq = 4'b0110;
    bus.htrans  = IDLE;
    step();
    checks++;
    if ({bus.hgrant, bus.hmaster} !== {4'b0010, 2'd0}) begin
      errors++;
      $display("FAIL park_grant: got grant=%b mst=%0d want grant=0010 mst=0", bus.hgrant, bus.hmaster);
    end
    step();
    checks++;
    if ({bus.hgrant, bus.hmaster} !== {4'b0010, 2'd1}) begin
      errors++;
      $display("FAIL park_handover: got grant=%b mst=%0d want grant=0010 mst=1", bus.hgrant, bus.hmaster);
    end
    bus.htrans = NONSEQ;
    bus.hburst = 3'b000;
    step();
    checks++;
    if (bus.hgrant !== 4'b0100) begin
      errors++;
      $display("FAIL single_rearb: got grant=%b want 0100", bus.hgrant);
    end
    bus.htrans = IDLE;
    step();
    checks++;
    if (bus.hmaster !== 2'd2) begin
      errors++;
      $display("FAIL single_handover: got mst=%0d want 2", bus.hmaster);
    end
    go_park();
    checks++;
    if ({bus.hgrant, bus.hmaster} !== {4'b0001, 2'd0}) begin
      errors++;
      $display("FAIL park_return: got grant=%b mst=%0d want grant=0001 mst=0", bus.hgrant, bus.hmaster);
    end
  endtask

  task automatic test_incr8();
    logic [3:0] exp_g;
    bus.hbusreq = 4'b0110;
    bus.htrans  = IDLE;
    step();
    step();
    checks++;
    if ({bus.hgrant, bus.hmaster} !== {4'b0010, 2'd1}) begin
      errors++;
      $display("FAIL incr8_owner: got grant=%b mst=%0d want grant=0010 mst=1", bus.hgrant, bus.hmaster);
    end
    for (int b = 1; b <= 8; b++) begin
      bus.htrans = (b == 1) ? NONSEQ : SEQ;
      bus.hburst = 3'b101;
      if (b == 4) begin
        bus.hready = 1'b0;
        step();
        checks++;
        if ({bus.hgrant, bus.hmaster} !== {4'b0010, 2'd1}) begin
          errors++;
          $display("FAIL incr8_stall: got grant=%b mst=%0d want grant=0010 mst=1", bus.hgrant, bus.hmaster);
        end
        bus.hready = 1'b1;
      end
      step();
      exp_g = (b == 8) ? 4'b0100 : 4'b0010;
      checks++;
      if (bus.hgrant !== exp_g) begin
        errors++;
        $display("FAIL incr8_beat%0d: got grant=%b want %b", b, bus.hgrant, exp_g);
      end
    end
    bus.htrans = IDLE;
    step();
    checks++;
    if (bus.hmaster !== 2'd2) begin
      errors++;
      $display("FAIL incr8_handover: got mst=%0d want 2", bus.hmaster);
    end
    go_park();
  endtask

  task automatic test_round_robin();
    logic [3:0] hist [0:8];
    logic [3:0] win_or;
    logic [1:0] exp_m;
    logic [3:0] exp_g;
    bus.hbusreq = 4'b1111;
    bus.htrans  = IDLE;
    bus.hburst  = 3'b000;
    step();
    exp_m = 2'd1;
    exp_g = 4'b0010;
    hist[0] = bus.hgrant;
    checks++;
    if (bus.hgrant !== exp_g) begin
      errors++;
      $display("FAIL rr_first: got grant=%b want %b", bus.hgrant, exp_g);
    end
    for (int k = 0; k < 8; k++) begin
      bus.htrans = IDLE;
      step();
      checks++;
      if (bus.hmaster !== exp_m) begin
        errors++;
        $display("FAIL rr_owner[%0d]: got mst=%0d want %0d", k, bus.hmaster, exp_m);
      end
      bus.htrans = NONSEQ;
      step();
      exp_m = exp_m + 2'd1;
      exp_g = 4'b0001 << exp_m;
      hist[k+1] = bus.hgrant;
      checks++;
      if (bus.hgrant !== exp_g) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got grant=%b want %b", k, bus.hgrant, exp_g);
      end
    end
    for (int w = 0; w <= 5; w++) begin
      win_or = hist[w] | hist[w+1] | hist[w+2] | hist[w+3];
      checks++;
      if (win_or !== 4'b1111) begin
        errors++;
        $display("FAIL rr_fair[%0d]: got grants_or=%b want 1111", w, win_or);
      end
    end
    go_park();
  endtask

  task automatic test_lock();
    bus.hbusreq = 4'b1001;
    bus.hlock   = 4'b1000;
    bus.htrans  = IDLE;
    bus.hburst  = 3'b000;
    step();
    checks++;
    if (bus.hgrant !== 4'b1000) begin
      errors++;
      $display("FAIL lock_grant: got grant=%b want 1000", bus.hgrant);
    end
    step();
    checks++;
    if ({bus.hgrant, bus.hmaster, bus.hmastlock} !== {4'b1000, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL lock_owner: got grant=%b mst=%0d lock=%b want grant=1000 mst=3 lock=1",
               bus.hgrant, bus.hmaster, bus.hmastlock);
    end
    for (int t = 0; t < 3; t++) begin
      bus.htrans = NONSEQ;
      step();
      checks++;
      if ({bus.hgrant, bus.hmastlock} !== {4'b1000, 1'b1}) begin
        errors++;
        $display("FAIL lock_hold[%0d]: got grant=%b lock=%b want grant=1000 lock=1",
                 t, bus.hgrant, bus.hmastlock);
      end
    end
    bus.hlock   = 4'b0000;
    bus.hbusreq = 4'b0001;
    bus.htrans  = IDLE;
    step();
    checks++;
    if ({bus.hgrant, bus.hmastlock} !== {4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL lock_release: got grant=%b lock=%b want grant=0001 lock=0", bus.hgrant, bus.hmastlock);
    end
    step();
    checks++;
    if ({bus.hmaster, bus.hmastlock} !== {2'd0, 1'b0}) begin
      errors++;
      $display("FAIL lock_newowner: got mst=%0d lock=%b want mst=0 lock=0", bus.hmaster, bus.hmastlock);
    end
    go_park();
  endtask

  task automatic test_reset_mid_burst();
    bus.hbusreq = 4'b0010;
    bus.htrans  = IDLE;
    step();
    step();
    bus.htrans = NONSEQ;
    bus.hburst = 3'b111;
    step();
    bus.htrans = SEQ;
    repeat (3) step();
    checks++;
    if ({bus.hgrant, bus.hmaster} !== {4'b0010, 2'd1}) begin
      errors++;
      $display("FAIL incr16_owner: got grant=%b mst=%0d want grant=0010 mst=1", bus.hgrant, bus.hmaster);
    end
    #3 hreset_n = 1'b0;
    #1;
    checks++;
    if ({bus.hgrant, bus.hmaster, bus.hmastlock} !== {4'b0001, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got grant=%b mst=%0d lock=%b want grant=0001 mst=0 lock=0",
               bus.hgrant, bus.hmaster, bus.hmastlock);
    end
    step();
    hreset_n    = 1'b1;
    bus.hbusreq = 4'b0110;
    bus.htrans  = IDLE;
    step();
    step();
    checks++;
    if ({bus.hgrant, bus.hmaster} !== {4'b0010, 2'd1}) begin
      errors++;
      $display("FAIL post_reset_owner: got grant=%b mst=%0d want grant=0010 mst=1", bus.hgrant, bus.hmaster);
    end
    // A cleared counter never reaches 1 on SEQ alone, so the grant must stay put.
    bus.htrans = SEQ;
    bus.hburst = 3'b111;
    for (int s = 0; s < 12; s++) begin
      step();
      checks++;
      if (bus.hgrant !== 4'b0010) begin
        errors++;
        $display("FAIL post_reset_cnt[%0d]: got grant=%b want 0010", s, bus.hgrant);
      end
    end
    go_park();
  endtask

  initial begin
    test_reset();
    test_park_grant();
    test_incr8();
    test_round_robin();
    test_lock();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
